// File: rtl/dot_product_ctrl_if.sv
// dot_product_ctrl_if: host command, host write, RAM port and status signals of the dot-product sequencer
interface dot_product_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic                  host_wr_en;
    logic                  host_wr_sel;
    logic [ADDR_WIDTH-1:0] host_wr_addr;
    logic [DATA_WIDTH-1:0] host_wr_data;
    logic                  host_wr_ready;
    logic                  a_wr_en;
    logic                  b_wr_en;
    logic [ADDR_WIDTH-1:0] a_wr_addr;
    logic [ADDR_WIDTH-1:0] b_wr_addr;
    logic [DATA_WIDTH-1:0] a_wr_data;
    logic [DATA_WIDTH-1:0] b_wr_data;
    logic                  a_rd_en;
    logic                  b_rd_en;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic [ADDR_WIDTH-1:0] b_rd_addr;
    logic [DATA_WIDTH-1:0] a_rd_data;
    logic [DATA_WIDTH-1:0] b_rd_data;
    logic                  busy;
    logic                  done;
    logic [ACC_WIDTH-1:0]  result;
    modport master (
        output start, len, base_a, base_b, host_wr_en, host_wr_sel, host_wr_addr, host_wr_data,
        output a_rd_data, b_rd_data,
        input  host_wr_ready, a_wr_en, b_wr_en, a_wr_addr, b_wr_addr, a_wr_data, b_wr_data,
        input  a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, busy, done, result
    );
    modport slave (
        input  start, len, base_a, base_b, host_wr_en, host_wr_sel, host_wr_addr, host_wr_data,
        input  a_rd_data, b_rd_data,
        output host_wr_ready, a_wr_en, b_wr_en, a_wr_addr, b_wr_addr, a_wr_data, b_wr_data,
        output a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, busy, done, result
    );
endinterface

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: streams lockstep reads from A/B RAMs, multiply-accumulates, and gates host writes while busy
module dot_product_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input logic              clk,
    input logic              rst,
    dot_product_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LEN_MAX = LEN_ONE << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    state_t                  r_state;
    logic [ADDR_WIDTH:0]     r_len;
    logic [ADDR_WIDTH:0]     r_idx;
    logic [ADDR_WIDTH-1:0]   r_addr_a;
    logic [ADDR_WIDTH-1:0]   r_addr_b;
    logic                    r_rd_en;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]    r_result;
    logic [ADDR_WIDTH:0]     w_len;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]    w_sum;
    always_comb begin
        w_len  = bus.len > LEN_MAX ? LEN_MAX : bus.len;
        w_prod = (2*DATA_WIDTH)'(bus.a_rd_data) * (2*DATA_WIDTH)'(bus.b_rd_data);
        w_sum  = r_acc + (r_valid ? ACC_WIDTH'(w_prod) : '0);
    end
    // r_valid marks the cycle in which RAM data for a previously issued read is on a/b_rd_data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_idx    <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_rd_en  <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= r_rd_en;
            r_acc   <= w_sum;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_acc <= '0;
                    r_idx <= '0;
                    if (w_len == '0) begin
                        r_done   <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_state  <= READ;
                        r_len    <= w_len;
                        r_addr_a <= bus.base_a;
                        r_addr_b <= bus.base_b;
                        r_rd_en  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                READ: if (r_idx == r_len - LEN_ONE) begin
                    r_state <= DRAIN;
                    r_rd_en <= 1'b0;
                end else begin
                    r_idx    <= r_idx + LEN_ONE;
                    r_addr_a <= r_addr_a + ADDR_ONE;
                    r_addr_b <= r_addr_b + ADDR_ONE;
                end
                DRAIN: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= w_sum;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.a_rd_en       = r_rd_en;
    assign bus.b_rd_en       = r_rd_en;
    assign bus.a_rd_addr     = r_addr_a;
    assign bus.b_rd_addr     = r_addr_b;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.result        = r_result;
    assign bus.host_wr_ready = ~r_busy;
    assign bus.a_wr_en       = bus.host_wr_en & ~bus.host_wr_sel & ~r_busy;
    assign bus.b_wr_en       = bus.host_wr_en & bus.host_wr_sel & ~r_busy;
    assign bus.a_wr_addr     = bus.host_wr_addr;
    assign bus.b_wr_addr     = bus.host_wr_addr;
    assign bus.a_wr_data     = bus.host_wr_data;
    assign bus.b_wr_data     = bus.host_wr_data;
endmodule

// File: tb/tb_dot_product_ctrl.sv
// tb_dot_product_ctrl: directed checks of the dot-product sequencer against two behavioural RAMs
module tb_dot_product_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   rd_cnt, busy_cnt, done_cyc, en_diff;
    logic [19:0] res;
    logic [3:0]  cap_a [32];
    logic [3:0]  cap_b [32];
    logic [7:0]  ram_a [16];
    logic [7:0]  ram_b [16];

    dot_product_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ACC_WIDTH(20)) bus ();

    dot_product_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ACC_WIDTH(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.a_wr_en) ram_a[bus.a_wr_addr] <= bus.a_wr_data;
        if (bus.b_wr_en) ram_b[bus.b_wr_addr] <= bus.b_wr_data;
        if (bus.a_rd_en) bus.a_rd_data <= ram_a[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= ram_b[bus.b_rd_addr];
    end

    task automatic host_write(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_sel  = sel;
        bus.host_wr_addr = addr;
        bus.host_wr_data = data;
        @(negedge clk);
        bus.host_wr_en = 1'b0;
    endtask

    // Called at a negedge; start is sampled on the next edge (edge 0). k counts cycles after edge k-1.
    task automatic do_run(input logic [4:0] n, input logic [3:0] ba, input logic [3:0] bb);
        bus.start  = 1'b1;
        bus.len    = n;
        bus.base_a = ba;
        bus.base_b = bb;
        @(negedge clk);
        bus.start = 1'b0;
        rd_cnt = 0; busy_cnt = 0; done_cyc = 0; en_diff = 0; res = '0;
        for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
            if (bus.a_rd_en !== bus.b_rd_en) en_diff++;
            if (bus.a_rd_en === 1'b1) begin
                if (rd_cnt < 32) begin
                    cap_a[rd_cnt] = bus.a_rd_addr;
                    cap_b[rd_cnt] = bus.b_rd_addr;
                end
                rd_cnt++;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cyc = k;
                res = bus.result;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.len = '0; bus.base_a = '0; bus.base_b = '0;
        bus.host_wr_en = 1'b0; bus.host_wr_sel = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
        checks++; if (bus.result !== 20'd0) begin errors++; $display("FAIL reset_result got %0d want 0", bus.result); end
        checks++; if (bus.a_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b want 0", bus.a_rd_en); end
        checks++; if (bus.host_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0b want 1", bus.host_wr_ready); end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 4; i++) host_write(1'b0, 4'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) host_write(1'b1, 4'(i), 8'(i + 5));
        do_run(5'd4, 4'd0, 4'd0);
        checks++; if (rd_cnt != 4) begin errors++; $display("FAIL basic_rd_cycles got %0d want 4", rd_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_a[i] !== 4'(i)) begin errors++; $display("FAIL basic_a_addr[%0d] got %0d want %0d", i, cap_a[i], i); end
        end
        checks++; if (en_diff != 0) begin errors++; $display("FAIL basic_rd_en_equal got %0d diffs want 0", en_diff); end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL basic_done_cycle got %0d want 6", done_cyc); end
        checks++; if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles got %0d want 5", busy_cnt); end
        checks++; if (res !== 20'd70) begin errors++; $display("FAIL basic_result got %0d want 70", res); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", bus.done); end
        checks++; if (bus.result !== 20'd70) begin errors++; $display("FAIL basic_result_held got %0d want 70", bus.result); end
    endtask

    task automatic test_len_zero;
        do_run(5'd0, 4'd0, 4'd0);
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL len0_rd_cycles got %0d want 0", rd_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL len0_busy_cycles got %0d want 0", busy_cnt); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL len0_done_cycle got %0d want 1", done_cyc); end
        checks++; if (res !== 20'd0) begin errors++; $display("FAIL len0_result got %0d want 0", res); end
        @(negedge clk);
    endtask

    task automatic test_busy_block;
        bus.start = 1'b1; bus.len = 5'd4; bus.base_a = '0; bus.base_b = '0;
        @(negedge clk);
        rd_cnt = 0; done_cyc = 0; res = '0;
        for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
            if (k == 1) begin
                bus.host_wr_en = 1'b1; bus.host_wr_sel = 1'b0; bus.host_wr_addr = 4'd0; bus.host_wr_data = 8'd99;
                #1;
                checks++; if (bus.host_wr_ready !== 1'b0) begin errors++; $display("FAIL busy_wr_ready got %0b want 0", bus.host_wr_ready); end
                checks++; if (bus.a_wr_en !== 1'b0) begin errors++; $display("FAIL busy_a_wr_en got %0b want 0", bus.a_wr_en); end
            end
            if (k == 2) begin
                bus.host_wr_sel = 1'b1;
                #1;
                checks++; if (bus.b_wr_en !== 1'b0) begin errors++; $display("FAIL busy_b_wr_en got %0b want 0", bus.b_wr_en); end
            end
            if (k == 4) begin
                bus.start = 1'b0;
                bus.host_wr_en = 1'b0;
            end
            if (bus.a_rd_en === 1'b1) rd_cnt++;
            if (bus.done === 1'b1) begin
                done_cyc = k;
                res = bus.result;
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (rd_cnt != 4) begin errors++; $display("FAIL busy_no_restart_rd got %0d want 4", rd_cnt); end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL busy_done_cycle got %0d want 6", done_cyc); end
        checks++; if (res !== 20'd70) begin errors++; $display("FAIL busy_result got %0d want 70", res); end
        checks++; if (ram_a[0] !== 8'd1) begin errors++; $display("FAIL busy_ram_a0 got %0d want 1", ram_a[0]); end
        checks++; if (ram_b[0] !== 8'd5) begin errors++; $display("FAIL busy_ram_b0 got %0d want 5", ram_b[0]); end
    endtask

    task automatic test_back_to_back;
        do_run(5'd4, 4'd0, 4'd0);
        checks++; if (res !== 20'd70) begin errors++; $display("FAIL b2b_first_result got %0d want 70", res); end
        do_run(5'd3, 4'd1, 4'd1);
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL b2b_done_cycle got %0d want 5", done_cyc); end
        checks++; if (rd_cnt != 3) begin errors++; $display("FAIL b2b_rd_cycles got %0d want 3", rd_cnt); end
        checks++; if (res !== 20'd65) begin errors++; $display("FAIL b2b_second_result got %0d want 65", res); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int dones;
        bus.start = 1'b1; bus.len = 5'd4; bus.base_a = '0; bus.base_b = '0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", bus.busy); end
        checks++; if (bus.a_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en got %0b want 0", bus.a_rd_en); end
        checks++; if (bus.result !== 20'd0) begin errors++; $display("FAIL rst_mid_result got %0d want 0", bus.result); end
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
        do_run(5'd4, 4'd0, 4'd0);
        checks++; if (res !== 20'd70) begin errors++; $display("FAIL rst_mid_rerun_result got %0d want 70", res); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 16; i++) host_write(1'b0, 4'(i), 8'(i + 1));
        for (int i = 0; i < 16; i++) host_write(1'b1, 4'(i), 8'(16 - i));
        do_run(5'd4, 4'd14, 4'd0);
        checks++; if (rd_cnt != 4) begin errors++; $display("FAIL wrap_rd_cycles got %0d want 4", rd_cnt); end
        checks++; if (cap_a[0] !== 4'd14 || cap_a[1] !== 4'd15 || cap_a[2] !== 4'd0 || cap_a[3] !== 4'd1) begin
            errors++; $display("FAIL wrap_a_addr got %0d,%0d,%0d,%0d want 14,15,0,1", cap_a[0], cap_a[1], cap_a[2], cap_a[3]);
        end
        checks++; if (cap_b[0] !== 4'd0 || cap_b[1] !== 4'd1 || cap_b[2] !== 4'd2 || cap_b[3] !== 4'd3) begin
            errors++; $display("FAIL wrap_b_addr got %0d,%0d,%0d,%0d want 0,1,2,3", cap_b[0], cap_b[1], cap_b[2], cap_b[3]);
        end
        checks++; if (res !== 20'd520) begin errors++; $display("FAIL wrap_result got %0d want 520", res); end
        @(negedge clk);
    endtask

    task automatic test_full;
        for (int i = 0; i < 16; i++) host_write(1'b0, 4'(i), 8'd255);
        for (int i = 0; i < 16; i++) host_write(1'b1, 4'(i), 8'd255);
        do_run(5'd16, 4'd0, 4'd0);
        checks++; if (rd_cnt != 16) begin errors++; $display("FAIL full_rd_cycles got %0d want 16", rd_cnt); end
        checks++; if (done_cyc != 18) begin errors++; $display("FAIL full_done_cycle got %0d want 18", done_cyc); end
        checks++; if (res !== 20'd1040400) begin errors++; $display("FAIL full_result got %0d want 1040400", res); end
        @(negedge clk);
        do_run(5'd31, 4'd0, 4'd0);
        checks++; if (rd_cnt != 16) begin errors++; $display("FAIL clamp_rd_cycles got %0d want 16", rd_cnt); end
        checks++; if (done_cyc != 18) begin errors++; $display("FAIL clamp_done_cycle got %0d want 18", done_cyc); end
        checks++; if (res !== 20'd1040400) begin errors++; $display("FAIL clamp_result got %0d want 1040400", res); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_len_zero;
        test_busy_block;
        test_back_to_back;
        test_mid_reset;
        test_wrap;
        test_full;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
Sequencer that computes the dot product of two vectors held in two single-port-style RAMs (vector A RAM, vector B RAM). Each RAM has independent write and read ports, synchronous 1-cycle read latency, and registered data_out on read_en. On start, the block streams element reads from both RAMs in lockstep, multiply-accumulates the returned words, and reports the sum with a one-cycle done pulse. It also owns the RAM write ports, arbitrating host loads against its own activity: host writes are accepted only while idle.

Parameters:
ADDR_WIDTH, 4, RAM address width; max vector length 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM word width; elements are unsigned
ACC_WIDTH, 20, accumulator/result width; default 2*DATA_WIDTH+ADDR_WIDTH holds worst case without overflow

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin operation; sampled only in IDLE
len  in  ADDR_WIDTH+1  element count; values above 2**ADDR_WIDTH clamp to 2**ADDR_WIDTH
base_a  in  ADDR_WIDTH  first address in A RAM
base_b  in  ADDR_WIDTH  first address in B RAM
host_wr_en  in  1  host write request
host_wr_sel  in  1  0 = A RAM, 1 = B RAM
host_wr_addr  in  ADDR_WIDTH  host write address
host_wr_data  in  DATA_WIDTH  host write data
host_wr_ready  out  1  high when a host write is accepted (= !busy)
a_wr_en, b_wr_en  out  1  RAM write enables
a_wr_addr, b_wr_addr  out  ADDR_WIDTH  RAM write addresses (host_wr_addr)
a_wr_data, b_wr_data  out  DATA_WIDTH  RAM write data (host_wr_data)
a_rd_en, b_rd_en  out  1  RAM read enables (always equal)
a_rd_addr, b_rd_addr  out  ADDR_WIDTH  RAM read addresses
a_rd_data, b_rd_data  in  DATA_WIDTH  RAM data_out, valid the cycle after the read_en edge
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse, result valid
result  out  ACC_WIDTH  dot product; held until the next done

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, acc=0, idx=0, rd_en=0, wr_en=0. The controller does not touch RAM contents on reset.
- States:
  - IDLE -> READ when start=1 and clamped len>0. This latches len, base_a, base_b and clears acc/idx.
  - IDLE with start=1 and len=0: stay IDLE, done=1 next cycle, result=0.
  - READ -> DRAIN after issuing element len-1.
  - DRAIN -> IDLE unconditionally.
- READ: a_rd_en=b_rd_en=1 each cycle. a_rd_addr=(base_a+idx) mod 2**ADDR_WIDTH, b likewise. idx increments by 1 per cycle. Exactly len read cycles are issued, back-to-back.
- Read outputs are decoded from registered state only, with no combinational path from inputs.
- Pipeline: a valid flag delays rd_en by one cycle. When the flag is set, acc <= acc + a_rd_data*b_rd_data.
  - The product is a full 2*DATA_WIDTH unsigned value, zero-extended.
  - The sum wraps mod 2**ACC_WIDTH.
- DRAIN: the final product is accumulated, and result <= acc + final product with done <= 1 on the same edge.
- Latency: done is high in the cycle after edge len+1, counting the start-sampling edge as edge 0. The rd_en cycles are edges 1..len.
- busy: 1 in READ and DRAIN, 0 in IDLE including the done cycle. A new start is accepted in the done cycle.
- start while busy: ignored, no queueing.
- Host writes: a_wr_en = host_wr_en & !host_wr_sel & !busy; b_wr_en = host_wr_en & host_wr_sel & !busy. Writes requested while busy are dropped; the host must hold until host_wr_ready=1.
- Reset mid-operation: abort immediately to reset values, with no done pulse. The next start behaves normally.

Test Plan:
- A[0..3]=1,2,3,4 and B[0..3]=5,6,7,8 via host port; start, base_a=base_b=0, len=4 -> rd_en high 4 cycles with addr 0,1,2,3; done 5 cycles after the start edge; result=70; busy high 5 cycles.
- len=0, start -> no rd_en, done next cycle, result=0, busy never high.
- All 16 entries of A and B = 255, len=16 -> result=1040400; second run with len=31 -> clamped to 16, same result.
- Wrap: base_a=14, base_b=0, len=4 -> a_rd_addr 14,15,0,1 and b_rd_addr 0,1,2,3; result matches the software model.
- start pulsed mid-run and host_wr_en asserted while busy -> no restart, host_wr_ready=0, a_wr_en/b_wr_en=0, RAM unchanged; back-to-back start in the done cycle is accepted.
- rst asserted on the 2nd READ cycle -> next cycle busy=0, rd_en=0, result=0, no done; a subsequent start with len=4 gives result=70.
